// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared definitions for the RV32I memory-access stage.
//   - funct3 codes for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - MEM stage FSM state encoding
//   - bubble instruction word (addi x0,x0,0)
//   - access_dropped(): 1 when a load/store must be dropped because it is
//     misaligned for its size or uses an unsupported funct3
package rv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] NOP_INST_C = 32'h0000_0013;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_RSP = 1'b1
    } mem_state_e;

    // Unsupported funct3 codes are folded into the same "drop" path as
    // misaligned addresses so the pipeline always makes forward progress.
    function automatic logic access_dropped(input logic       is_load,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic drop;
        drop = 1'b1;
        if (is_load) begin
            case (funct3)
                F3_LB, F3_LBU: drop = 1'b0;
                F3_LH, F3_LHU: drop = addr_lo[0];
                F3_LW:         drop = |addr_lo;
                default:       drop = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_SB:   drop = 1'b0;
                F3_SH:   drop = addr_lo[0];
                F3_SW:   drop = |addr_lo;
                default: drop = 1'b1;
            endcase
        end
        return drop;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: combinational load-data aligner / extender.
// Ports:
//   rdata   in  32  response word from the data bus
//   addr_lo in  2   byte offset of the access within the word
//   funct3  in  3   load type (LB, LH, LW, LBU, LHU)
//   value   out 32  selected lane, sign- or zero-extended to 32 bits
module mem_load_ext
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    // Bring the addressed lane down to bit 0; alignment was already
    // enforced upstream so a halfword never straddles the word boundary.
    logic [31:0] shifted;
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        value = shifted;
        case (funct3)
            F3_LB:   value = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  value = {24'h0, shifted[7:0]};
            F3_LH:   value = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  value = {16'h0, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage RV32I pipeline (EX_MEM -> MEM_WB).
// Issues loads/stores on a req/gnt/rvalid bus, aligns/extends load data,
// and stalls the upstream pipe until the access retires.
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   EX_pc/EX_inst/EX_rfwe        instruction currently in EX_MEM
//   EX_alur                      ALU result or effective address
//   EX_memre/EX_memwe/EX_sdata   load / store flags and store data
//   dmem_req/we/be/addr/wdata    bus request side
//   dmem_gnt                     request accepted this cycle
//   dmem_rvalid/dmem_rdata       read response
//   mem_stall                    hold IF..EX_MEM this cycle
//   MEM_pc/MEM_inst/MEM_rfwe/MEM_rfwd  values for MEM_WB
//   mem_misalign/mem_buserr      one-cycle error pulses
//
// Bus handshake: dmem_req is held (with stable we/be/addr/wdata) until the
// cycle dmem_gnt is seen high; that cycle completes the request. For a read,
// dmem_rvalid is honoured only in a cycle strictly after the grant cycle
// (WAIT_RSP); rvalid seen in IDLE is a stray response and has no effect.
module mem_access_stage
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = NOP_INST_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_inst,
    input  logic        EX_rfwe,
    input  logic [31:0] EX_alur,
    input  logic        EX_memre,
    input  logic        EX_memwe,
    input  logic [31:0] EX_sdata,
    output logic        dmem_req,
    input  logic        dmem_gnt,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] MEM_pc,
    output logic [31:0] MEM_inst,
    output logic        MEM_rfwe,
    output logic [31:0] MEM_rfwd,
    output logic        mem_misalign,
    output logic        mem_buserr
);

    mem_state_e  state, state_nxt;
    logic [15:0] cnt, cnt_nxt, cnt_inc;

    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        is_mem;
    logic        dropped;
    logic        at_limit;
    logic [31:0] load_val;

    logic        req_c, we_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        retire, err, misalign_c, buserr_c;
    logic [31:0] rfwd_c;

    assign funct3   = EX_inst[14:12];
    assign addr_lo  = EX_alur[1:0];
    assign is_mem   = EX_memre | EX_memwe;
    assign dropped  = access_dropped(EX_memre, funct3, addr_lo);
    assign at_limit = (cnt >= 16'(TIMEOUT - 1));
    assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    mem_load_ext u_load_ext (
        .rdata   (dmem_rdata),
        .addr_lo (addr_lo),
        .funct3  (funct3),
        .value   (load_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_c      = 1'b0;
        we_c       = 1'b0;
        be_c       = 4'b0000;
        wdata_c    = 32'h0;
        retire     = 1'b0;
        err        = 1'b0;
        misalign_c = 1'b0;
        buserr_c   = 1'b0;
        rfwd_c     = 32'h0;

        case (state)
            ST_IDLE: begin
                if (!is_mem) begin
                    retire = 1'b1;
                    rfwd_c = EX_alur;
                end else if (dropped) begin
                    retire     = 1'b1;
                    err        = 1'b1;
                    misalign_c = 1'b1;
                end else begin
                    req_c = 1'b1;
                    if (EX_memwe) begin
                        we_c = 1'b1;
                        case (funct3)
                            F3_SB: begin
                                be_c    = 4'b0001 << addr_lo;
                                wdata_c = {4{EX_sdata[7:0]}};
                            end
                            F3_SH: begin
                                be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
                                wdata_c = {2{EX_sdata[15:0]}};
                            end
                            default: begin
                                be_c    = 4'b1111;
                                wdata_c = EX_sdata;
                            end
                        endcase
                    end else begin
                        be_c = 4'b1111;
                    end

                    // A grant always wins over the timeout in the same cycle.
                    if (dmem_gnt) begin
                        if (EX_memwe) begin
                            retire = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT_RSP;
                        end
                        cnt_nxt = 16'd0;
                    end else if (at_limit) begin
                        retire   = 1'b1;
                        err      = 1'b1;
                        buserr_c = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end

            ST_WAIT_RSP: begin
                if (dmem_rvalid) begin
                    retire    = 1'b1;
                    rfwd_c    = load_val;
                    state_nxt = ST_IDLE;
                end else if (at_limit) begin
                    retire    = 1'b1;
                    err       = 1'b1;
                    buserr_c  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase

        if (retire) begin
            cnt_nxt = 16'd0;
        end
    end

    // Every output is gated by rst so the bus request and all results drop
    // the moment reset is asserted, independent of the clock.
    assign dmem_req     = req_c & ~rst;
    assign dmem_we      = we_c & ~rst;
    assign dmem_be      = rst ? 4'b0000 : be_c;
    assign dmem_addr    = (req_c & ~rst) ? {EX_alur[31:2], 2'b00} : 32'h0;
    assign dmem_wdata   = rst ? 32'h0 : wdata_c;

    assign mem_stall    = is_mem & ~retire & ~rst;
    assign MEM_pc       = (retire & ~rst) ? EX_pc : 32'h0;
    assign MEM_inst     = (retire & ~rst) ? EX_inst : NOP_INST;
    assign MEM_rfwe     = retire & ~rst & EX_rfwe & ~err;
    assign MEM_rfwd     = (retire & ~rst) ? rfwd_c : 32'h0;
    assign mem_misalign = misalign_c & ~rst;
    assign mem_buserr   = buserr_c & ~rst;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import rv_mem_pkg::*;

    localparam int TO = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] EX_pc, EX_inst, EX_alur, EX_sdata;
    logic        EX_rfwe, EX_memre, EX_memwe;
    logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall, MEM_rfwe, mem_misalign, mem_buserr;
    logic [31:0] MEM_pc, MEM_inst, MEM_rfwd;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    mem_access_stage #(.TIMEOUT(TO), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .EX_pc(EX_pc), .EX_inst(EX_inst), .EX_rfwe(EX_rfwe), .EX_alur(EX_alur),
        .EX_memre(EX_memre), .EX_memwe(EX_memwe), .EX_sdata(EX_sdata),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .MEM_pc(MEM_pc), .MEM_inst(MEM_inst),
        .MEM_rfwe(MEM_rfwe), .MEM_rfwd(MEM_rfwd),
        .mem_misalign(mem_misalign), .mem_buserr(mem_buserr)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] op);
        return {17'h0, f3, 5'd1, op};
    endfunction

    task automatic drive_ex(input logic [31:0] pc, input logic [31:0] inst, input logic rfwe,
                            input logic [31:0] alur, input logic re, input logic we,
                            input logic [31:0] sdata);
        EX_pc = pc; EX_inst = inst; EX_rfwe = rfwe; EX_alur = alur;
        EX_memre = re; EX_memwe = we; EX_sdata = sdata;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic drive_idle();
        drive_ex(32'h0, NOP, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // ---------------- reference model helpers ----------------
    function automatic int acc_size(input logic is_load, input logic [2:0] f3);
        if (f3 == 3'b000 || (is_load && f3 == 3'b100)) return 1;
        if (f3 == 3'b001 || (is_load && f3 == 3'b101)) return 2;
        if (f3 == 3'b010) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int a,
                                               input logic [2:0] f3);
        logic [31:0] b, h;
        b = (rdata >> (8 * a)) & 32'hFF;
        h = (rdata >> (8 * a)) & 32'hFFFF;
        case (f3)
            3'b000:  return (b ^ 32'h80) - 32'h80;
            3'b100:  return b;
            3'b001:  return (h ^ 32'h8000) - 32'h8000;
            3'b101:  return h;
            default: return rdata;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_ex(32'h40, mk_inst(F3_SW, 7'b0100011), 1'b1, 32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", dmem_req); end
        n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
        n_checks++; if (MEM_inst !== NOP) begin n_fail++; $display("FAIL rst_inst: got %h want %h", MEM_inst, NOP); end
        n_checks++; if (MEM_pc !== 32'h0 || MEM_rfwe !== 1'b0 || MEM_rfwd !== 32'h0 || dmem_be !== 4'h0)
            begin n_fail++; $display("FAIL rst_outs: pc %h rfwe %b rfwd %h be %h want zeros", MEM_pc, MEM_rfwe, MEM_rfwd, dmem_be); end
        step();
        rst = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (dmem_req !== 1'b1 || MEM_pc !== 32'h40)
            begin n_fail++; $display("FAIL rst_release: req %b pc %h want 1 00000040", dmem_req, MEM_pc); end
        step();
        drive_idle();
    endtask

    task automatic test_alu();
        drive_ex(32'h100, mk_inst(3'b000, 7'b0010011), 1'b1, 32'h1234, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (MEM_rfwd !== 32'h1234 || MEM_rfwe !== 1'b1 || mem_stall !== 1'b0 || MEM_pc !== 32'h100)
            begin n_fail++; $display("FAIL alu: rfwd %h rfwe %b stall %b pc %h want 1234 1 0 100", MEM_rfwd, MEM_rfwe, mem_stall, MEM_pc); end
        step();
    endtask

    task automatic test_lb();
        logic [31:0] inst;
        inst = mk_inst(F3_LB, 7'b0000011);
        drive_ex(32'h104, inst, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_stall !== 1'b1 || dmem_req !== 1'b1 || dmem_be !== 4'hF || dmem_addr !== 32'h100 || dmem_we !== 1'b0)
            begin n_fail++; $display("FAIL lb_c0: stall %b req %b be %h addr %h we %b", mem_stall, dmem_req, dmem_be, dmem_addr, dmem_we); end
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_stall !== 1'b1 || dmem_req !== 1'b0 || MEM_inst !== NOP)
            begin n_fail++; $display("FAIL lb_c1: stall %b req %b inst %h want 1 0 %h", mem_stall, dmem_req, MEM_inst, NOP); end
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF_0000;
        @(negedge clk);
        n_checks++; if (mem_stall !== 1'b0 || MEM_rfwd !== 32'hFFFF_FF80 || MEM_rfwe !== 1'b1 || MEM_inst !== inst)
            begin n_fail++; $display("FAIL lb_c2: stall %b rfwd %h rfwe %b inst %h want 0 ffffff80 1 %h", mem_stall, MEM_rfwd, MEM_rfwe, MEM_inst, inst); end
        step();
        drive_idle();
    endtask

    task automatic test_sh();
        int stalls;
        stalls = 0;
        drive_ex(32'h108, mk_inst(F3_SH, 7'b0100011), 1'b0, 32'h202, 1'b0, 1'b1, 32'h0000_ABCD);
        for (int c = 0; c < 4; c++) begin
            dmem_gnt = (c == 3);
            @(negedge clk);
            if (mem_stall === 1'b1) stalls++;
            n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD)
                begin n_fail++; $display("FAIL sh_bus c%0d: req %b we %b be %b wdata %h", c, dmem_req, dmem_we, dmem_be, dmem_wdata); end
            step();
        end
        n_checks++; if (stalls !== 3) begin n_fail++; $display("FAIL sh_stall_cycles: got %0d want 3", stalls); end
        drive_idle();
    endtask

    task automatic test_misalign();
        drive_ex(32'h10C, mk_inst(F3_LW, 7'b0000011), 1'b1, 32'h101, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (dmem_req !== 1'b0 || mem_misalign !== 1'b1 || mem_stall !== 1'b0 || MEM_rfwe !== 1'b0 || MEM_pc !== 32'h10C)
            begin n_fail++; $display("FAIL misalign: req %b mis %b stall %b rfwe %b pc %h", dmem_req, mem_misalign, mem_stall, MEM_rfwe, MEM_pc); end
        step();
        drive_idle();
        @(negedge clk);
        n_checks++; if (mem_misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse: got %b want 0", mem_misalign); end
        step();
    endtask

    task automatic test_timeout();
        drive_ex(32'h110, mk_inst(F3_LHU, 7'b0000011), 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        for (int w = 1; w <= TO; w++) begin
            @(negedge clk);
            n_checks++;
            if (w < TO) begin
                if (mem_buserr !== 1'b0 || mem_stall !== 1'b1)
                    begin n_fail++; $display("FAIL timeout_wait w%0d: buserr %b stall %b want 0 1", w, mem_buserr, mem_stall); end
            end else begin
                if (mem_buserr !== 1'b1 || mem_stall !== 1'b0 || MEM_rfwe !== 1'b0 || MEM_pc !== 32'h110)
                    begin n_fail++; $display("FAIL timeout_err: buserr %b stall %b rfwe %b pc %h", mem_buserr, mem_stall, MEM_rfwe, MEM_pc); end
            end
            step();
        end
        // Late response arrives while an ALU op is in the stage.
        drive_ex(32'h114, mk_inst(3'b000, 7'b0010011), 1'b1, 32'h55, 1'b0, 1'b0, 32'h0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        @(negedge clk);
        n_checks++; if (MEM_rfwd !== 32'h55 || MEM_rfwe !== 1'b1 || mem_buserr !== 1'b0)
            begin n_fail++; $display("FAIL late_rvalid: rfwd %h rfwe %b buserr %b want 55 1 0", MEM_rfwd, MEM_rfwe, mem_buserr); end
        step();
        drive_idle();
    endtask

    task automatic test_reset_mid();
        drive_ex(32'h118, mk_inst(F3_LW, 7'b0000011), 1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %b want 1", dmem_req); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_async: got %b want 0", dmem_req); end
        step();
        rst = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_stall !== 1'b1 || dmem_req !== 1'b0)
            begin n_fail++; $display("FAIL rmid_wait: stall %b req %b want 1 0", mem_stall, dmem_req); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (MEM_inst !== NOP || mem_stall !== 1'b0)
            begin n_fail++; $display("FAIL rmid_rst: inst %h stall %b want %h 0", MEM_inst, mem_stall, NOP); end
        step();
        rst = 1'b0;
        drive_ex(32'h11C, mk_inst(3'b000, 7'b0010011), 1'b1, 32'h77, 1'b0, 1'b0, 32'h0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++; if (MEM_rfwd !== 32'h77 || MEM_pc !== 32'h11C)
            begin n_fail++; $display("FAIL rmid_stray: rfwd %h pc %h want 77 11c", MEM_rfwd, MEM_pc); end
        step();
        drive_idle();
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            int kind, g, r, a, sz, rc, req_end;
            logic [2:0] f3;
            logic [31:0] addr, pc, inst, sdata, rdata, exp_rfwd, exp_wdata, got;
            logic rfwe, is_ld, is_st, mis, e_mis, e_bus, exp_rfwe;
            logic [3:0] exp_be;

            kind  = $urandom_range(0, 2);
            is_ld = (kind == 1);
            is_st = (kind == 2);
            f3    = (($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) :
                     (is_ld ? (($urandom_range(0, 1) == 1) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2)))
                            : 3'($urandom_range(0, 2))));
            addr  = $urandom;
            sz    = acc_size(is_ld, f3);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2) addr[0] = 1'b0;
                if (sz == 4) addr[1:0] = 2'b00;
            end
            a     = int'(addr[1:0]);
            pc    = $urandom;
            sdata = $urandom;
            rdata = $urandom;
            rfwe  = 1'($urandom_range(0, 1));
            g     = $urandom_range(0, 5);
            r     = $urandom_range(1, 5);
            inst  = $urandom;
            inst[14:12] = f3;

            mis = (is_ld || is_st) && (sz == 0 || (a % sz) != 0);
            e_mis = 1'b0; e_bus = 1'b0; exp_rfwd = 32'h0; rc = 0; req_end = -1;
            if (!is_ld && !is_st) begin
                exp_rfwd = addr;
            end else if (mis) begin
                e_mis = 1'b1;
            end else begin
                req_end = (g < TO) ? g : TO - 1;
                if (g >= TO) begin rc = TO - 1; e_bus = 1'b1; end
                else if (is_st) rc = g;
                else if (r <= TO) begin rc = g + r; exp_rfwd = model_load(rdata, a, f3); end
                else begin rc = g + TO; e_bus = 1'b1; end
            end
            exp_rfwe = rfwe && !e_mis && !e_bus;
            exp_q.push_back(exp_rfwd);

            exp_be = 4'hF; exp_wdata = sdata;
            if (is_st && sz == 1) begin exp_be = 4'(1 << a); exp_wdata = {24'h0, sdata[7:0]} * 32'h0101_0101; end
            if (is_st && sz == 2) begin exp_be = (a >= 2) ? 4'hC : 4'h3; exp_wdata = {16'h0, sdata[15:0]} * 32'h0001_0001; end

            drive_ex(pc, inst, rfwe, addr, is_ld, is_st, sdata);
            for (int c = 0; c <= rc; c++) begin
                dmem_gnt    = (req_end >= 0) && (c == g);
                dmem_rvalid = 1'b0;
                if (c <= g && $urandom_range(0, 3) == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = $urandom;
                end
                if (is_ld && !mis && c == g + r) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                end
                @(negedge clk);
                n_checks++; if (mem_stall !== ((is_ld || is_st) && c < rc))
                    begin n_fail++; $display("FAIL rnd_stall t%0d c%0d: got %b", t, c, mem_stall); end
                n_checks++; if (dmem_req !== (c <= req_end))
                    begin n_fail++; $display("FAIL rnd_req t%0d c%0d: got %b want %b", t, c, dmem_req, (c <= req_end)); end
                if (c <= req_end) begin
                    n_checks++; if (dmem_addr !== {addr[31:2], 2'b00} || dmem_we !== is_st || dmem_be !== exp_be ||
                                    (is_st && dmem_wdata !== exp_wdata))
                        begin n_fail++; $display("FAIL rnd_bus t%0d: addr %h we %b be %h wdata %h want %h %b %h %h",
                                                 t, dmem_addr, dmem_we, dmem_be, dmem_wdata, {addr[31:2], 2'b00}, is_st, exp_be, exp_wdata); end
                end
                if (c == rc) begin
                    got = exp_q.pop_front();
                    n_checks++; if (MEM_inst !== inst || MEM_pc !== pc || MEM_rfwe !== exp_rfwe)
                        begin n_fail++; $display("FAIL rnd_retire t%0d: inst %h pc %h rfwe %b want %h %h %b", t, MEM_inst, MEM_pc, MEM_rfwe, inst, pc, exp_rfwe); end
                    n_checks++; if (mem_misalign !== e_mis || mem_buserr !== e_bus)
                        begin n_fail++; $display("FAIL rnd_err t%0d: mis %b bus %b want %b %b", t, mem_misalign, mem_buserr, e_mis, e_bus); end
                    if (!e_mis && !e_bus) begin
                        n_checks++; if (MEM_rfwd !== got)
                            begin n_fail++; $display("FAIL rnd_rfwd t%0d: got %h want %h", t, MEM_rfwd, got); end
                    end
                end else begin
                    n_checks++; if (MEM_inst !== NOP || mem_misalign !== 1'b0 || mem_buserr !== 1'b0)
                        begin n_fail++; $display("FAIL rnd_bubble t%0d c%0d: inst %h mis %b bus %b", t, c, MEM_inst, mem_misalign, mem_buserr); end
                end
                step();
            end
        end
        drive_idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        dmem_rdata = 32'h0;
        drive_idle();
        test_reset();
        test_alu();
        test_lb();
        test_sh();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random(200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
